// File: rtl/pipe_stage_reg.sv
// Elastic DEPTH-slice pipeline register with valid/ready flow control and flush-to-bubble.
// Define PIPE_STAGE_SKID_EN to give each slice a skid entry and a registered ready.
module pipe_stage_reg #(
  parameter int unsigned DATA_W = 101,
  parameter int unsigned CTRL_W = 3,
  parameter int unsigned DEPTH  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl
);

  logic              valid_q [DEPTH];
  logic              valid_d [DEPTH];
  logic [DATA_W-1:0] data_q  [DEPTH];
  logic [DATA_W-1:0] data_d  [DEPTH];
  logic [CTRL_W-1:0] ctrl_q  [DEPTH];
  logic [CTRL_W-1:0] ctrl_d  [DEPTH];

  // Entry offered to each slice by its upstream neighbour
  logic              up_valid [DEPTH];
  logic [DATA_W-1:0] up_data  [DEPTH];
  logic [CTRL_W-1:0] up_ctrl  [DEPTH];
  // rdy[i] is slice i's ready; rdy[DEPTH] is the downstream ready
  logic              rdy      [DEPTH+1];

`ifdef PIPE_STAGE_SKID_EN
  logic              skid_v_q    [DEPTH];
  logic              skid_v_d    [DEPTH];
  logic [DATA_W-1:0] skid_data_q [DEPTH];
  logic [DATA_W-1:0] skid_data_d [DEPTH];
  logic [CTRL_W-1:0] skid_ctrl_q [DEPTH];
  logic [CTRL_W-1:0] skid_ctrl_d [DEPTH];
`endif

  always_comb begin
    up_valid[0] = in_valid;
    up_data[0]  = in_data;
    up_ctrl[0]  = in_ctrl;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      up_valid[i] = valid_q[i-1];
      up_data[i]  = data_q[i-1];
      up_ctrl[i]  = ctrl_q[i-1];
    end
  end

`ifdef PIPE_STAGE_SKID_EN
  // A slice accepts while its skid entry is free, so ready comes straight from a flop
  always_comb begin
    rdy[DEPTH] = out_ready;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      rdy[i] = !skid_v_q[i];
    end
  end
`else
  always_comb begin : ready_chain
    logic r;
    r          = out_ready;
    rdy[DEPTH] = out_ready;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      r              = !valid_q[DEPTH-1-k] || r;
      rdy[DEPTH-1-k] = r;
    end
  end
`endif

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      valid_d[i] = valid_q[i];
      data_d[i]  = data_q[i];
      ctrl_d[i]  = ctrl_q[i];
`ifdef PIPE_STAGE_SKID_EN
      skid_v_d[i]    = skid_v_q[i];
      skid_data_d[i] = skid_data_q[i];
      skid_ctrl_d[i] = skid_ctrl_q[i];
`endif
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (flush) begin
        valid_d[i] = 1'b0;
        ctrl_d[i]  = '0;
`ifdef PIPE_STAGE_SKID_EN
        skid_v_d[i]    = 1'b0;
        skid_ctrl_d[i] = '0;
`endif
      end else begin
`ifdef PIPE_STAGE_SKID_EN
        // Skid full means main is full too; draining main promotes the older skid entry
        if (skid_v_q[i]) begin
          if (valid_q[i] && rdy[i+1]) begin
            data_d[i]   = skid_data_q[i];
            ctrl_d[i]   = skid_ctrl_q[i];
            skid_v_d[i] = 1'b0;
          end
        end else if (up_valid[i]) begin
          if (!valid_q[i] || rdy[i+1]) begin
            valid_d[i] = 1'b1;
            data_d[i]  = up_data[i];
            ctrl_d[i]  = up_ctrl[i];
          end else begin
            skid_v_d[i]    = 1'b1;
            skid_data_d[i] = up_data[i];
            skid_ctrl_d[i] = up_ctrl[i];
          end
        end else if (valid_q[i] && rdy[i+1]) begin
          valid_d[i] = 1'b0;
        end
`else
        if (up_valid[i] && rdy[i]) begin
          valid_d[i] = 1'b1;
          data_d[i]  = up_data[i];
          ctrl_d[i]  = up_ctrl[i];
        end else if (valid_q[i] && rdy[i+1]) begin
          valid_d[i] = 1'b0;
        end
`endif
      end
    end
  end

  // Falling-edge state, matching the rest of the core's pipeline registers
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        data_q[i]  <= '0;
        ctrl_q[i]  <= '0;
`ifdef PIPE_STAGE_SKID_EN
        skid_v_q[i]    <= 1'b0;
        skid_data_q[i] <= '0;
        skid_ctrl_q[i] <= '0;
`endif
      end
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        valid_q[i] <= valid_d[i];
        data_q[i]  <= data_d[i];
        ctrl_q[i]  <= ctrl_d[i];
`ifdef PIPE_STAGE_SKID_EN
        skid_v_q[i]    <= skid_v_d[i];
        skid_data_q[i] <= skid_data_d[i];
        skid_ctrl_q[i] <= skid_ctrl_d[i];
`endif
      end
    end
  end

  assign in_ready  = flush || rdy[0];
  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];
  assign out_ctrl  = valid_q[DEPTH-1] ? ctrl_q[DEPTH-1] : '0;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: reset, streaming, stall, flush and random back-pressure.
module tb_pipe_stage_reg;

  localparam int unsigned DATA_W = 101;
  localparam int unsigned CTRL_W = 3;
  localparam int unsigned DEPTH  = 3;
  localparam int unsigned EW     = DATA_W + CTRL_W;
`ifdef PIPE_STAGE_SKID_EN
  localparam int CAP = 2 * DEPTH;
`else
  localparam int CAP = DEPTH;
`endif

  logic              clk;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;

  pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [EW-1:0] sb [$];
  int n_checks  = 0;
  int n_errors  = 0;
  int cyc       = 0;
  int pops      = 0;
  int accepts   = 0;
  int first_pop = -1;
  int last_pop  = -1;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [DATA_W-1:0] rnd_data();
    return DATA_W'({$urandom(), $urandom(), $urandom(), $urandom()});
  endfunction

  // Drive at posedge, settle, then score the handshakes the next falling edge will perform
  task automatic step(input logic v, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                      input logic ordy, input logic fl);
    logic [EW-1:0] want;
    in_valid  = v;
    in_data   = d;
    in_ctrl   = c;
    out_ready = ordy;
    flush     = fl;
    #1;
    if (fl) begin
      check("flush_in_ready", 128'(in_ready), 128'(1));
      sb.delete();
    end else begin
      if (!out_valid) check("ctrl_gate", 128'(out_ctrl), 128'(0));
      if (out_valid && out_ready) begin
        check("out_has_entry", 128'(out_valid), 128'(sb.size() != 0));
        if (sb.size() != 0) begin
          want = sb.pop_front();
          check("out_entry", 128'({out_data, out_ctrl}), 128'(want));
          pops++;
          if (first_pop < 0) first_pop = cyc;
          last_pop = cyc;
        end
      end
      if (v && in_ready) begin
        sb.push_back({d, c});
        accepts++;
      end
    end
    @(posedge clk);
    cyc++;
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, DATA_W'(0), CTRL_W'(0), ordy, 1'b0);
  endtask

  task automatic drain();
    for (int k = 0; k < 8 * DEPTH + 20 && sb.size() != 0; k++) idle(1'b1);
    repeat (DEPTH + 2) idle(1'b1);
    check("drain_empty", 128'(sb.size()), 128'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int mark;
    int a0;
    int p0;
    int guard;
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_ctrl   = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_out_data",  128'(out_data),  128'(0));
    check("rst_out_ctrl",  128'(out_ctrl),  128'(0));
    check("rst_in_ready",  128'(in_ready),  128'(1));
    @(posedge clk);
    rst = 1'b0;

    // Back-to-back stream, no gaps, first exit DEPTH samples later
    mark = cyc; first_pop = -1; p0 = pops;
    for (int k = 1; k <= 10; k++) step(1'b1, DATA_W'(k), CTRL_W'(k), 1'b1, 1'b0);
    repeat (DEPTH + 2) idle(1'b1);
    check("stream_latency", 128'(first_pop - mark), 128'(DEPTH));
    check("stream_count",   128'(pops - p0),        128'(10));
    check("stream_no_gap",  128'(last_pop - first_pop), 128'(9));
    drain();

    // Stall with a full pipeline, then release in order
    a0 = accepts;
    repeat (2 * CAP + 2) step(1'b1, rnd_data(), CTRL_W'($urandom()), 1'b0, 1'b0);
    check("stall_capacity", 128'(accepts - a0), 128'(CAP));
    #1;
    check("stall_in_ready", 128'(in_ready), 128'(0));
    drain();

    // Flush a full pipeline of write-enabled entries plus an offered one
    repeat (CAP) step(1'b1, rnd_data(), CTRL_W'(5), 1'b0, 1'b0);
    step(1'b1, DATA_W'(32'hDEAD), CTRL_W'(5), 1'b0, 1'b1);
    #1;
    check("flush_out_valid", 128'(out_valid), 128'(0));
    check("flush_out_ctrl",  128'(out_ctrl),  128'(0));
    repeat (2 * DEPTH + 4) idle(1'b1);
    check("flush_no_output", 128'(sb.size()), 128'(0));

    // Asynchronous reset with entries in flight
    step(1'b1, DATA_W'(8'h11), CTRL_W'(1), 1'b1, 1'b0);
    step(1'b1, DATA_W'(8'h22), CTRL_W'(2), 1'b1, 1'b0);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("midrst_out_valid", 128'(out_valid), 128'(0));
    check("midrst_out_data",  128'(out_data),  128'(0));
    check("midrst_out_ctrl",  128'(out_ctrl),  128'(0));
    check("midrst_in_ready",  128'(in_ready),  128'(1));
    sb.delete();
    @(negedge clk);
    @(posedge clk);
    rst = 1'b0;
    repeat (DEPTH + 2) idle(1'b1);
    mark = cyc; first_pop = -1;
    step(1'b1, DATA_W'(8'h33), CTRL_W'(3), 1'b1, 1'b0);
    repeat (DEPTH + 2) idle(1'b1);
    check("post_rst_latency", 128'(first_pop - mark), 128'(DEPTH));

    // Random valid/ready for 10k accepted entries
    a0 = accepts; guard = 0;
    while (accepts - a0 < 10000 && guard < 40000) begin
      step($urandom_range(0, 99) < 70, rnd_data(), CTRL_W'($urandom()),
           $urandom_range(0, 99) < 70, 1'b0);
      guard++;
    end
    check("rand_accepted", 128'(accepts - a0), 128'(10000));
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
